// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU result channels (valid/ready),
// register-file write port and idle flag. master = producers/regfile side, slave = arbiter.
interface wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;

  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        idle;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, lsu_funct3,
    input  alu_ready, lsu_ready,
    input  w_enable, w_addr, w_data, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, lsu_funct3,
    output alu_ready, lsu_ready,
    output w_enable, w_addr, w_data, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two 2-entry FIFOs (ALU, LSU) drained round-robin into one regfile write port.
// Ports: clk, rst (sync, active-high), rdy (global freeze when 0), bus (wb_arbiter_if.slave).
// Optional: define WB_LOAD_EXT_EN to sign/zero-extend LSU data by lsu_funct3 at acceptance.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  wb_arbiter_if.slave bus
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  typedef logic [36:0] ent_t;

  // channel index: 0 = ALU, 1 = LSU
  ent_t        mem_q  [2][2];
  logic        wptr_q [2];
  logic        wptr_d [2];
  logic        rptr_q [2];
  logic        rptr_d [2];
  logic [1:0]  cnt_q  [2];
  logic [1:0]  cnt_d  [2];

  gnt_e        last_q, last_d;
  logic        w_en_q, w_en_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;

  logic [31:0] lsu_data_x;
  ent_t        ent [2];
  ent_t        head;
  logic [1:0]  ne;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic        gnt_v;
  logic        gnt_idx;

`ifdef WB_LOAD_EXT_EN
  always_comb begin
    lsu_data_x = bus.lsu_data;
    unique case (bus.lsu_funct3)
      3'b000:  lsu_data_x = {{24{bus.lsu_data[7]}}, bus.lsu_data[7:0]};
      3'b001:  lsu_data_x = {{16{bus.lsu_data[15]}}, bus.lsu_data[15:0]};
      3'b100:  lsu_data_x = {24'd0, bus.lsu_data[7:0]};
      3'b101:  lsu_data_x = {16'd0, bus.lsu_data[15:0]};
      default: ;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^bus.lsu_funct3;
  assign lsu_data_x    = bus.lsu_data;
`endif

  assign ne   = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
  assign full = {cnt_q[1] == 2'd2, cnt_q[0] == 2'd2};

  // ready ignores a same-cycle pop on purpose
  assign bus.alu_ready = rdy & ~rst & ~full[0];
  assign bus.lsu_ready = rdy & ~rst & ~full[1];

  // rd=0 completes the handshake but never occupies the FIFO
  assign push[0] = bus.alu_valid & bus.alu_ready & (bus.alu_rd != 5'd0);
  assign push[1] = bus.lsu_valid & bus.lsu_ready & (bus.lsu_rd != 5'd0);

  assign ent[0] = {bus.alu_rd, bus.alu_data};
  assign ent[1] = {bus.lsu_rd, lsu_data_x};

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = 1'b0;
    if (rdy) begin
      unique case (1'b1)
        ne[0] & ne[1]: begin
          gnt_v   = 1'b1;
          gnt_idx = (last_q == GNT_ALU);
        end
        ne[0] & ~ne[1]: begin
          gnt_v   = 1'b1;
          gnt_idx = 1'b0;
        end
        ~ne[0] & ne[1]: begin
          gnt_v   = 1'b1;
          gnt_idx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop  = gnt_v ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign head = gnt_idx ? mem_q[1][rptr_q[1]]
                        : mem_q[0][rptr_q[0]];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wptr_d[c] = wptr_q[c] ^ push[c];
      rptr_d[c] = rptr_q[c] ^ pop[c];
      cnt_d[c]  = cnt_q[c] + {1'b0, push[c]}
                           - {1'b0, pop[c]};
    end
    last_d   = last_q;
    w_en_d   = w_en_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (rdy) begin
      w_en_d = gnt_v;
      if (gnt_v) begin
        last_d   = gnt_e'(gnt_idx);
        w_addr_d = head[36:32];
        w_data_d = head[31:0];
      end
    end
  end

  // storage needs no reset: a slot is only read after being written
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst && push[c]) begin
        mem_q[c][wptr_q[c]] <= ent[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= 1'b0;
        rptr_q[c] <= 1'b0;
        cnt_q[c]  <= 2'd0;
      end
      last_q   <= GNT_ALU;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      last_q   <= last_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign bus.w_enable = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.idle     = ~ne[0] & ~ne[1] & ~w_en_q;

endmodule
